// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sequencer sharing one multi-cycle word memory between fetch and load/store
// Ports: clk, reset (sync, active-high); i_req/i_addr -> i_ready/i_valid/i_rdata (fetch);
//        d_req/d_we/d_addr/d_wdata -> d_ready/d_valid/d_rdata (data); mem_addr/mem_din/mem_read/mem_write/mem_dout (memory).
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic port_q, port_d;
  logic we_q, we_d;
  logic [31:0] addr_q, addr_d, din_q, din_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic busy, fin, acc;
  assign busy = state_q == BUSY;
  assign fin = busy && cnt_q == 4'd1;
  // last_q/port_q: 1 = data port; on a tie the port not granted last wins
  assign i_ready = !reset && !busy && i_req && (!d_req || last_q);
  assign d_ready = !reset && !busy && d_req && (!i_req || !last_q);
  assign acc = i_ready || d_ready;
  always_comb begin
    state_d = fin ? IDLE : acc ? BUSY : state_q;
    cnt_d = busy ? cnt_q - 4'd1 : acc ? 4'(LATENCY) : cnt_q;
    last_d = acc ? d_ready : last_q;
    port_d = acc ? d_ready : port_q;
    we_d = i_ready ? 1'b0 : d_ready ? d_we : we_q;
    addr_d = i_ready ? i_addr : d_ready ? d_addr : addr_q;
    din_d = i_ready ? '0 : d_ready ? d_wdata : din_q;
    i_rdata_d = fin && !port_q ? mem_dout : i_rdata_q;
    d_rdata_d = fin && port_q && !we_q ? mem_dout : d_rdata_q;
    i_valid_d = fin && !port_q;
    d_valid_d = fin && port_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b0;
      port_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      port_q <= port_d;
      we_q <= we_d;
      addr_q <= addr_d;
      din_q <= din_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
    end
  end
  assign i_valid = i_valid_q;
  assign d_valid = d_valid_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign mem_addr = busy ? addr_q : '0;
  assign mem_din = busy ? din_q : '0;
  assign mem_read = busy && !we_q;
  // a store commits exactly once, on its last busy cycle
  assign mem_write = fin && we_q;
endmodule
